// File: rtl/keypad_bcd_entry_module_pkg.sv
// rtl/keypad_bcd_entry_module_pkg.sv - shared types and constants for the keypad BCD entry block
// Purpose: debounce state encoding, frame-result encoding, keypad map and key codes.
// Ports: none (package).
package keypad_bcd_entry_module_pkg;

  localparam int DEF_SCAN_DIV        = 200;
  localparam int DEF_DEBOUNCE_FRAMES = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } kp_state_t;

  typedef enum logic [1:0] {
    FR_NONE  = 2'd0,
    FR_KEY   = 2'd1,
    FR_MULTI = 2'd2
  } frame_res_t;

  localparam logic [3:0] KEY_CLEAR = 4'hC;
  localparam logic [3:0] KEY_STAR  = 4'hE;
  localparam logic [3:0] KEY_HASH  = 4'hF;

  // Indexed [row][column]; row r is Row_In[r], column c is driven by Col_Out[c].
  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1,     4'h2, 4'h3,     4'hA},
    '{4'h4,     4'h5, 4'h6,     4'hB},
    '{4'h7,     4'h8, 4'h9,     KEY_CLEAR},
    '{KEY_STAR, 4'h0, KEY_HASH, 4'hD}
  };

endpackage

// File: rtl/keypad_bcd_entry_module_col_scanner.sv
// rtl/keypad_bcd_entry_module_col_scanner.sv - column scan, row sampling and per-frame key classification
// Purpose: drives one column low per slot, samples rows at the end of each slot and
//   classifies each 4-column frame as NONE, KEY(code) or MULTI.
// Ports:
//   CLK, RSTn          clock, asynchronous active-low reset
//   Row_In[3:0]        keypad rows, active-low
//   Col_Out[3:0]       column drive, one-hot-low
//   frame_done         high in the cycle whose row sample closes a frame
//   frame_res          frame classification, valid with frame_done
//   frame_code         key code for FR_KEY, valid with frame_done
module keypad_col_scanner
  import keypad_bcd_entry_module_pkg::*;
#(
  parameter int SCAN_DIV = DEF_SCAN_DIV
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [3:0] Row_In,
  output logic [3:0] Col_Out,
  output logic       frame_done,
  output frame_res_t frame_res,
  output logic [3:0] frame_code
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);

  logic [SLOT_W-1:0] slot_q;
  logic [1:0]        col_q;
  logic [1:0]        acc_cnt_q;   // low rows seen so far this frame, saturating at 2
  logic [3:0]        acc_code_q;
  logic              sample_now;
  logic [2:0]        low_cnt;
  logic [3:0]        sample_code;
  logic [2:0]        total;
  logic [1:0]        merged_cnt;
  logic [3:0]        merged_code;

  assign sample_now = (slot_q == SLOT_LAST);
  assign frame_done = sample_now && (col_q == 2'd3);
  assign Col_Out    = ~(4'b0001 << col_q);

  // Classification is combinational on the closing sample so the top level can
  // register its decision on the same edge that takes the last sample.
  always_comb begin
    low_cnt     = '0;
    sample_code = '0;
    for (int r = 0; r < 4; r++) begin
      if (!Row_In[r]) begin
        low_cnt     = low_cnt + 3'd1;
        sample_code = KEY_MAP[r][col_q];
      end
    end
    total       = {1'b0, acc_cnt_q} + low_cnt;
    merged_cnt  = (total >= 3'd2) ? 2'd2 : total[1:0];
    // With exactly one low row in total, it came either from earlier columns or from this one.
    merged_code = (acc_cnt_q == 2'd1) ? acc_code_q : sample_code;
    frame_code  = merged_code;
    case (merged_cnt)
      2'd0:    frame_res = FR_NONE;
      2'd1:    frame_res = FR_KEY;
      default: frame_res = FR_MULTI;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      slot_q     <= '0;
      col_q      <= 2'd0;
      acc_cnt_q  <= 2'd0;
      acc_code_q <= 4'h0;
    end else if (sample_now) begin
      slot_q     <= '0;
      col_q      <= col_q + 2'd1;
      acc_cnt_q  <= frame_done ? 2'd0 : merged_cnt;
      acc_code_q <= frame_done ? 4'h0 : merged_code;
    end else begin
      slot_q <= slot_q + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/keypad_bcd_entry_module.sv
// rtl/keypad_bcd_entry_module.sv - debounced 4x4 keypad to two-digit packed BCD entry
// Purpose: debounces per-frame key results and shifts accepted digits into a BCD register.
// Ports:
//   CLK, RSTn       clock, asynchronous active-low reset
//   Row_In[3:0]     keypad rows, active-low
//   Col_Out[3:0]    column drive, one-hot-low
//   Result[7:0]     {tens, units} packed BCD
//   Key_Code[3:0]   last accepted key
//   Key_Valid       one-cycle accept pulse
//   Key_Held        accepted key still pressed
module keypad_bcd_entry_module
  import keypad_bcd_entry_module_pkg::*;
#(
  parameter int SCAN_DIV        = DEF_SCAN_DIV,
  parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [3:0] Row_In,
  output logic [3:0] Col_Out,
  output logic [7:0] Result,
  output logic [3:0] Key_Code,
  output logic       Key_Valid,
  output logic       Key_Held
);

  localparam int STB_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [STB_W-1:0] STB_TARGET = STB_W'(DEBOUNCE_FRAMES);
  localparam logic [STB_W-1:0] STB_ONE    = STB_W'(1);

  logic       frame_done;
  frame_res_t frame_res;
  logic [3:0] frame_code;

  kp_state_t         state_q, state_d;
  logic [3:0]        cand_q, cand_d;
  logic [STB_W-1:0]  stable_q, stable_d, stable_inc;
  logic [7:0]        result_q, result_d;
  logic [3:0]        key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              accept;

  keypad_col_scanner #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .Row_In     (Row_In),
    .Col_Out    (Col_Out),
    .frame_done (frame_done),
    .frame_res  (frame_res),
    .frame_code (frame_code)
  );

  assign stable_inc = (stable_q == STB_TARGET) ? stable_q : stable_q + STB_ONE;

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    stable_d    = stable_q;
    result_d    = result_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    accept      = 1'b0;

    if (frame_done) begin
      case (state_q)
        ST_IDLE: begin
          if (frame_res == FR_KEY) begin
            if (DEBOUNCE_FRAMES == 1) begin
              accept  = 1'b1;
              state_d = ST_HELD;
            end else begin
              cand_d   = frame_code;
              stable_d = STB_ONE;
              state_d  = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (frame_res == FR_KEY && frame_code == cand_q) begin
            stable_d = stable_inc;
            if (stable_inc == STB_TARGET) begin
              accept  = 1'b1;
              state_d = ST_HELD;
            end
          end else if (frame_res == FR_KEY) begin
            cand_d   = frame_code;
            stable_d = STB_ONE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (frame_res == FR_NONE) begin
            stable_d = STB_ONE;
            state_d  = (DEBOUNCE_FRAMES == 1) ? ST_IDLE : ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (frame_res == FR_NONE) begin
            stable_d = stable_inc;
            if (stable_inc == STB_TARGET) state_d = ST_IDLE;
          end else begin
            state_d = ST_HELD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (accept) begin
      key_valid_d = 1'b1;
      key_code_d  = frame_code;
      if (frame_code <= 4'd9) result_d = {result_q[3:0], frame_code};
      else if (frame_code == KEY_CLEAR) result_d = 8'h00;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= ST_IDLE;
      cand_q      <= 4'h0;
      stable_q    <= '0;
      result_q    <= 8'h00;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      stable_q    <= stable_d;
      result_q    <= result_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign Result    = result_q;
  assign Key_Code  = key_code_q;
  assign Key_Valid = key_valid_q;
  assign Key_Held  = (state_q == ST_HELD) || (state_q == ST_RELEASE);

endmodule

// File: doc/keypad_bcd_entry_module.md
Name: keypad_bcd_entry_module

Overview:
- Scans a 4x4 matrix front-panel keypad, debounces it and assembles a two-digit BCD number from the keys pressed.
- The input-side counterpart of the multiplexed seven-segment display driver. The display multiplexes outputs; this block multiplexes input reads.
- Result has the same 8-bit packed-BCD format the display consumes (high nibble = tens, low nibble = units), so the two blocks connect directly.

Parameters:
- SCAN_DIV, 200, clock cycles each column stays driven (one column slot).
- DEBOUNCE_FRAMES, 3, consecutive identical full-scan results required to accept a press or a release (range 1..15).

Ports:
- CLK  in  1  system clock, rising edge.
- RSTn  in  1  reset, asynchronous, active-low.
- Row_In  in  4  keypad rows, active-low (external pull-ups). A pressed key pulls its row low while its column is driven.
- Col_Out  out  4  column drive, one-hot-low.
- Result  out  8  packed BCD entry: {tens, units}.
- Key_Code  out  4  code of the last accepted key.
- Key_Valid  out  1  one-cycle pulse when a key is accepted.
- Key_Held  out  1  high while an accepted key remains pressed (state HELD or RELEASE).

Behaviour:
- Reset (asynchronous, RSTn=0): all registers take these values immediately:
  - Col_Out=4'b1110, Result=8'h00, Key_Code=4'h0, Key_Valid=0, Key_Held=0.
  - State IDLE; slot counter, column index and stable counter = 0.
  - Reset in mid-scan or mid-debounce discards all partial state.
- Scan:
  - Slot counter runs 0..SCAN_DIV-1. In the last cycle of a slot, Row_In is sampled for the current column.
  - The column index then advances 0->1->2->3->0. Col_Out[c]=0 only for the current column.
  - A frame is 4 slots (4*SCAN_DIV cycles). The frame ends at the sample of column 3.
- Frame result: count low row bits over all 4 samples.
  - Zero low bits -> NONE.
  - Exactly one -> KEY(code).
  - Two or more -> MULTI.
- Key map (row r = Row_In bit r, column c):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E(*), 0, F(#), D
- State machine, evaluated once per frame end:
  - IDLE:
    - KEY(k) -> candidate=k, stable=1, go to DEBOUNCE.
    - Anything else -> stay in IDLE.
    - If DEBOUNCE_FRAMES=1, KEY(k) goes straight to HELD and accepts k.
  - DEBOUNCE:
    - KEY(candidate) -> stable+1. On reaching DEBOUNCE_FRAMES: accept, go to HELD.
    - KEY(other) -> candidate=other, stable=1.
    - NONE or MULTI -> IDLE.
  - HELD:
    - NONE -> RELEASE, stable=1. If DEBOUNCE_FRAMES=1, go straight to IDLE.
    - KEY or MULTI -> stay in HELD. No auto-repeat.
  - RELEASE:
    - NONE -> stable+1. On reaching DEBOUNCE_FRAMES, go to IDLE.
    - KEY or MULTI -> HELD.
- Accept (registered, visible in the cycle after the frame-end sample):
  - Key_Valid=1 for exactly one cycle; Key_Code=k.
  - k in 0..9 -> Result <= {Result[3:0], k}. The old tens digit is discarded.
  - k=C -> Result <= 8'h00.
  - Other codes -> Result unchanged.
- Latency: the key must be stable across DEBOUNCE_FRAMES whole frames. Key_Valid rises one cycle after the end of the DEBOUNCE_FRAMES-th consecutive matching frame.
- The stable counter saturates and never wraps. Counter widths come from the parameters.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, DEBOUNCE, HELD, RELEASE);
  - frame-result encoding (NONE, KEY, MULTI);
  - key-map constant table and codes KEY_CLEAR=4'hC, KEY_STAR=4'hE, KEY_HASH=4'hF;
  - default SCAN_DIV and DEBOUNCE_FRAMES.
- One sub-module, keypad_col_scanner: slot counter, column drive, row sampling, and frame-result generation (frame_done pulse, result type, code).
- The top level holds the debounce state machine and the BCD shift register.

Test Plan (bench uses SCAN_DIV=4, DEBOUNCE_FRAMES=3, giving 16-cycle frames):
- Reset, then idle with Row_In=4'hF -> Col_Out cycles 1110, 1101, 1011, 0111 with 4 cycles per column. Result=00, Key_Valid never asserts.
- Press "1", then "2", each held 5 frames and released 5 frames -> Key_Valid pulses twice, Key_Code 1 then 2, Result 01 then 12.
- Press "4" for only 2 frames, then release -> no Key_Valid, Result unchanged. Then press "3", "5", "7" with full holds -> Result 57.
- Bounce: "8" for 1 frame, NONE for 1 frame, "8" for 4 frames -> exactly one accept, at the end of the 3rd frame of the final 4-frame run.
- Hold "9" for 10 frames; drop it for 1 frame mid-hold; also press "9"+"6" together -> a single Key_Valid only. MULTI from the start (IDLE) -> nothing accepted.
- Result=57, press C -> Result=00, Key_Code=C. Assert RSTn=0 mid-DEBOUNCE -> outputs return to reset values asynchronously, and the pending key is not accepted after release of reset.
